// File: rtl/condiciona_pkg.sv
// Shared definitions for the button conditioner: FSM state encoding,
// debounce length calculation and a one-hot test helper.
package condiciona_pkg;

  localparam int NUM_BOTOES = 4;

  // db_estado exposes this encoding directly, so the values are fixed
  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRANDO   = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTANDO    = 2'd3
  } estado_t;

  // Debounce window in clock cycles; 64-bit product avoids overflow for fast clocks
  function automatic int calc_deb_cycles(input longint clock_freq, input longint debounce_ms);
    return int'((clock_freq * debounce_ms) / 64'd1000);
  endfunction

  // True when exactly one button is pressed
  function automatic logic eh_one_hot(input logic [NUM_BOTOES-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/condiciona_botoes_sincronizador.sv
// Two-flop synchronizer for the raw button levels, async active-low clear.
module sincronizador_2ff #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // first flop may go metastable; second one gives the FSM a clean level
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/condiciona_botoes.sv
// Button conditioner: debounces 4 push buttons, accepts only single-button
// presses (one pulse per press), flags and drains multi-button presses.
// Optional macro CONDICIONA_SYNC_EN inserts a 2-flop input synchronizer.
module condiciona_botoes
  import condiciona_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50000000,
  parameter int DEBOUNCE_MS = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_BOTOES-1:0] botoes_raw,
  output logic [NUM_BOTOES-1:0] botoes,
  output logic                  jogada_pulso,
  output logic                  multipla,
  output logic [1:0]            db_estado
);

  localparam int DEB_CYCLES = calc_deb_cycles(longint'(CLOCK_FREQ), longint'(DEBOUNCE_MS));
  localparam int CW         = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_FIM = CW'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_deb_invalido
    $error("condiciona_botoes: DEB_CYCLES must be >= 2");
  end

  logic [NUM_BOTOES-1:0] s;

`ifdef CONDICIONA_SYNC_EN
  sincronizador_2ff #(.W(NUM_BOTOES)) u_sinc (
    .clock (clock),
    .reset (reset),
    .d     (botoes_raw),
    .q     (s)
  );
`else
  assign s = botoes_raw;
`endif

  estado_t               estado, estado_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [NUM_BOTOES-1:0] cand, cand_d;
  logic [NUM_BOTOES-1:0] botoes_d;
  logic                  pulso_d, multipla_d;

  // state and all outputs are registered together
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado       <= OCIOSO;
      cnt          <= '0;
      cand         <= '0;
      botoes       <= '0;
      jogada_pulso <= 1'b0;
      multipla     <= 1'b0;
    end else begin
      estado       <= estado_d;
      cnt          <= cnt_d;
      cand         <= cand_d;
      botoes       <= botoes_d;
      jogada_pulso <= pulso_d;
      multipla     <= multipla_d;
    end
  end

  // next-state and next-output logic; counter stops at CNT_FIM, never wraps
  always_comb begin
    estado_d   = estado;
    cnt_d      = cnt;
    cand_d     = cand;
    botoes_d   = botoes;
    pulso_d    = 1'b0;
    multipla_d = multipla;
    unique case (estado)
      OCIOSO: begin
        botoes_d = '0;
        if (s != '0) begin
          cand_d   = s;
          cnt_d    = '0;
          estado_d = FILTRANDO;
        end
      end
      FILTRANDO: begin
        if (s == '0) begin
          cnt_d    = '0;
          estado_d = OCIOSO;
        end else if (s != cand) begin
          // pattern changed mid-window: restart filtering on the new pattern
          cand_d = s;
          cnt_d  = '0;
        end else if (cnt == CNT_FIM) begin
          if (eh_one_hot(cand)) begin
            botoes_d = cand;
            pulso_d  = 1'b1;
            estado_d = PRESSIONADO;
          end else begin
            multipla_d = 1'b1;
            botoes_d   = '0;
            cnt_d      = '0;
            estado_d   = SOLTANDO;
          end
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
      PRESSIONADO: begin
        // release or an added button both end the press
        if (s != botoes) begin
          botoes_d = '0;
          cnt_d    = '0;
          estado_d = SOLTANDO;
        end
      end
      SOLTANDO: begin
        if (s != '0) begin
          cnt_d = '0;
        end else if (cnt == CNT_FIM) begin
          multipla_d = 1'b0;
          cnt_d      = '0;
          estado_d   = OCIOSO;
        end else begin
          cnt_d = cnt + 1'b1;
        end
      end
    endcase
  end

  assign db_estado = estado;

endmodule

// File: tb/tb_condiciona_botoes.sv
// Randomized + directed bench for condiciona_botoes against a run-length
// based reference model of the debounce rules.
module tb_condiciona_botoes;

  localparam int CF  = 1000;
  localparam int DM  = 4;
  localparam int DEB = CF * DM / 1000;
`ifdef CONDICIONA_SYNC_EN
  localparam int SYNC = 1;
`else
  localparam int SYNC = 0;
`endif
  localparam int LAT = DEB + 1 + 2 * SYNC;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] botoes_raw = 4'b0;
  logic [3:0] botoes;
  logic       jogada_pulso;
  logic       multipla;
  logic [1:0] db_estado;

  always #5 clock = ~clock;

  condiciona_botoes #(.CLOCK_FREQ(CF), .DEBOUNCE_MS(DM)) dut (
    .clock        (clock),
    .reset        (reset),
    .botoes_raw   (botoes_raw),
    .botoes       (botoes),
    .jogada_pulso (jogada_pulso),
    .multipla     (multipla),
    .db_estado    (db_estado)
  );

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 = waiting/filtering, 1 = held, 2 = releasing
  int         md, run, t, t_ent;
  logic [3:0] sh1, sh2, prev_s;
  logic [3:0] e_botoes;
  logic       e_pulso, e_mult;
  logic [1:0] e_est;
  int         nstep, dut_pulses, pulse_step;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s t=%0d observed=%b expected=%b", tag, t, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs == exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    md = 0; run = 0; t_ent = 0;
    sh1 = '0; sh2 = '0; prev_s = '0;
    e_botoes = '0; e_pulso = 1'b0; e_mult = 1'b0; e_est = 2'd0;
  endtask

  // A press is accepted once the same nonzero pattern has been seen on
  // DEB+1 consecutive samples; release needs DEB zero samples after the
  // sample that started the release.
  task automatic model_step(input logic [3:0] raw);
    logic [3:0] s;
    s = (SYNC != 0) ? sh2 : raw;
    t++;
    if (s == prev_s) run++; else run = 1;
    prev_s  = s;
    e_pulso = 1'b0;
    case (md)
      0: begin
        if (s != 0 && run == DEB + 1) begin
          if ($countones(s) == 1) begin
            e_botoes = s; e_pulso = 1'b1; md = 1; e_est = 2'd2;
          end else begin
            e_mult = 1'b1; md = 2; t_ent = t; e_est = 2'd3;
          end
        end else begin
          e_botoes = '0;
          e_est = (s != 0) ? 2'd1 : 2'd0;
        end
      end
      1: if (s != e_botoes) begin
        e_botoes = '0; md = 2; t_ent = t; e_est = 2'd3;
      end
      default: if (s == 0 && run >= DEB && (t - t_ent) >= DEB) begin
        e_mult = 1'b0; md = 0; e_est = 2'd0;
      end
    endcase
    sh2 = sh1;
    sh1 = raw;
  endtask

  task automatic step(input logic [3:0] raw);
    @(negedge clock);
    botoes_raw = raw;
    @(posedge clock);
    #1;
    nstep++;
    model_step(raw);
    chk("botoes", botoes, e_botoes);
    chk("jogada_pulso", {3'b0, jogada_pulso}, {3'b0, e_pulso});
    chk("multipla", {3'b0, multipla}, {3'b0, e_mult});
    chk("db_estado", {2'b0, db_estado}, {2'b0, e_est});
    if (jogada_pulso === 1'b1) begin
      dut_pulses++;
      pulse_step = nstep;
    end
  endtask

  task automatic hold(input logic [3:0] raw, input int n);
    for (int i = 0; i < n; i++) step(raw);
  endtask

  task automatic clr();
    nstep = 0; dut_pulses = 0; pulse_step = -1;
  endtask

  // asserts reset between edges, checks the async clear, releases mid high phase
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("rst_botoes", botoes, 4'b0);
    chk("rst_pulso", {3'b0, jogada_pulso}, 4'b0);
    chk("rst_multipla", {3'b0, multipla}, 4'b0);
    chk("rst_estado", {2'b0, db_estado}, 4'b0);
    model_reset();
    @(posedge clock);
    #2 reset = 1'b1;
  endtask

  initial begin
    t = 0;
    model_reset();
    clr();
    #3;
    chk("init_botoes", botoes, 4'b0);
    chk("init_pulso", {3'b0, jogada_pulso}, 4'b0);
    chk("init_multipla", {3'b0, multipla}, 4'b0);
    chk("init_estado", {2'b0, db_estado}, 4'b0);
    @(posedge clock);
    #2 reset = 1'b1;

    // clean press
    clr();
    hold(4'b0100, 20);
    chk_int("clean_pulses", dut_pulses, 1);
    chk_int("clean_pulse_edge", pulse_step, LAT);
    chk("clean_botoes_held", botoes, 4'b0100);
    hold(4'b0000, 10);
    chk("clean_botoes_rel", botoes, 4'b0000);

    // bounce then steady
    clr();
    hold(4'b0001, 2);
    hold(4'b0000, 1);
    hold(4'b0001, 12);
    chk_int("bounce_pulses", dut_pulses, 1);
    chk_int("bounce_pulse_edge", pulse_step, 3 + LAT);
    hold(4'b0000, 8);

    // two buttons at once
    clr();
    hold(4'b0011, 10);
    chk_int("multi_pulses", dut_pulses, 0);
    chk("multi_flag", {3'b0, multipla}, 4'b0001);
    chk("multi_botoes", botoes, 4'b0000);
    hold(4'b0000, 8);
    chk("multi_cleared", {3'b0, multipla}, 4'b0000);

    // extra button while held
    clr();
    hold(4'b1000, LAT + 2);
    hold(4'b1010, 10);
    chk("extra_botoes", botoes, 4'b0000);
    hold(4'b1000, 10);
    chk_int("extra_no_repeat", dut_pulses, 1);
    hold(4'b0000, 8);
    hold(4'b1000, LAT + 1);
    chk_int("extra_new_press", dut_pulses, 2);
    hold(4'b0000, 8);

    // reset while held, button still down afterwards
    clr();
    hold(4'b0010, LAT + 2);
    do_reset();
    clr();
    hold(4'b0010, LAT + 3);
    chk_int("rst_repress_pulses", dut_pulses, 1);
    chk_int("rst_repress_edge", pulse_step, LAT);
    hold(4'b0000, 8);

    // random segments
    for (int seg = 0; seg < 60; seg++) begin
      logic [3:0] v;
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 45) v = 4'b0;
      else if (r < 80) v = 4'(1 << $urandom_range(0, 3));
      else v = 4'($urandom_range(1, 15));
      hold(v, int'($urandom_range(1, 9)));
      if (seg % 17 == 16) do_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
